clock_display_scanner: RTL and testbench

Time-multiplexed 6-digit seven-segment driver that consumes the three 6-bit level values produced by the clock counter core (l0 = seconds, l1 = minutes, l2 = hours field). Splits each value into tens/ones decimal digits, scans one common-anode digit at a time with dead-time between digits, and blinks selected fields for the time-set UI. Sits directly downstream of the counter core and drives the board's display pins.

---
 rtl/clock_display_scanner.sv | 138 +++++++++++++
 tb/tb_clock_display_scanner.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_display_scanner.sv
// Six-digit multiplexed seven-segment scanner for the clock core.
// Frame-coherent input snapshot, per-slot dead time, field blinking.
module clock_display_scanner #(
  parameter int CLK_FREQ    = 1000000,
  parameter int SCAN_DIV    = 1000,
  parameter int DEAD_CYCLES = 2,
  parameter int BLINK_DIV   = 250000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enabled,
  input  logic [5:0] l0_in,
  input  logic [5:0] l1_in,
  input  logic [5:0] l2_in,
  input  logic [2:0] blink_mask,
  output logic [5:0] an_out,
  output logic [6:0] seg_out,
  output logic       dp_out
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] DEAD = SW'(DEAD_CYCLES);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  if (SCAN_DIV < 4 || DEAD_CYCLES >= SCAN_DIV ||
      BLINK_DIV < 1 || CLK_FREQ < 1) begin : g_param_err
    $error("clock_display_scanner: bad parameters");
  end

  logic [SW-1:0] scan_q, scan_d;
  logic [2:0]    idx_q, idx_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;
  logic [5:0]    s0_q, s1_q, s2_q;
  logic [5:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic       scan_wrap, frame_wrap, blink_wrap;
  logic [5:0] val;
  logic [5:0] tens, ones;
  logic [3:0] digit;
  logic       blank;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  always_comb begin
    scan_wrap  = (scan_q == SCAN_MAX);
    frame_wrap = scan_wrap && (idx_q == 3'd5);
    blink_wrap = (bcnt_q == BLINK_MAX);
    scan_d  = scan_wrap ? '0 : scan_q + 1'b1;
    idx_d   = idx_q;
    if (frame_wrap)
      idx_d = 3'd0;
    else if (scan_wrap)
      idx_d = idx_q + 3'd1;
    bcnt_d  = blink_wrap ? '0 : bcnt_q + 1'b1;
    phase_d = phase_q ^ blink_wrap;

    case (idx_q[2:1])
      2'd0: begin
        val   = s0_q;
        blank = blink_mask[0] && phase_q;
      end
      2'd1: begin
        val   = s1_q;
        blank = blink_mask[1] && phase_q;
      end
      default: begin
        val   = s2_q;
        blank = blink_mask[2] && phase_q;
      end
    endcase
    tens  = val / 6'd10;
    ones  = val % 6'd10;
    digit = idx_q[0] ? tens[3:0] : ones[3:0];

    // Segments follow the slot even while the anode is blanked.
    an_d  = (scan_q < DEAD) ? 6'h3f : ~(6'd1 << idx_q);
    seg_d = blank ? 7'h7f : seg_of(digit);
    dp_d  = blank || !(idx_q == 3'd2 || idx_q == 3'd4);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      scan_q  <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
      s0_q    <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      an_q    <= 6'h3f;
      seg_q   <= 7'h7f;
      dp_q    <= 1'b1;
    end else if (!enabled) begin
      an_q  <= 6'h3f;
      seg_q <= 7'h7f;
      dp_q  <= 1'b1;
    end else begin
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      if (frame_wrap) begin
        s0_q <= l0_in;
        s1_q <= l1_in;
        s2_q <= l2_in;
      end
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an_out  = an_q;
  assign seg_out = seg_q;
  assign dp_out  = dp_q;

endmodule

// File: tb/tb_clock_display_scanner.sv
// Randomized bench for clock_display_scanner against an arithmetic
// model of the display timeline (enabled-cycle count since reset).
module tb_clock_display_scanner;

  localparam int SD = 4;
  localparam int DC = 1;
  localparam int BD = 16;
  localparam int FR = 6 * SD;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enabled = 1'b1;
  logic [5:0] l0 = '0, l1 = '0, l2 = '0;
  logic [2:0] mask = '0;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  clock_display_scanner #(
    .CLK_FREQ(1000000), .SCAN_DIV(SD),
    .DEAD_CYCLES(DC), .BLINK_DIV(BD)
  ) dut (
    .clock(clock), .reset(reset), .enabled(enabled),
    .l0_in(l0), .l1_in(l1), .l2_in(l2),
    .blink_mask(mask),
    .an_out(an), .seg_out(seg), .dp_out(dp)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  // model state: enabled edges since reset, captured frame values
  int         t = 0;
  int         snap [3] = '{0, 0, 0};
  logic [13:0] exp_v, obs_v;
  int         cur_d;
  logic       cur_act;
  logic       cur_ph;

  function automatic logic [6:0] segc(input int d);
    logic [6:0] tab [10] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return tab[d];
  endfunction

  task automatic step();
    int s, d, f, v, dig;
    logic ph, blank;
    logic [5:0] a;
    cur_act = 1'b0;
    cur_d   = -1;
    cur_ph  = 1'b0;
    if (!reset || !enabled) begin
      exp_v = {6'h3f, 7'h7f, 1'b1};
    end else begin
      s  = t % SD;
      d  = (t / SD) % 6;
      ph = ((t / BD) % 2) == 1;
      f  = d / 2;
      v  = snap[f];
      dig = (d % 2 == 1) ? v / 10 : v % 10;
      blank = mask[f] && ph;
      a = 6'h3f;
      if (s >= DC) a[d] = 1'b0;
      exp_v = {a, blank ? 7'h7f : segc(dig),
               !(!blank && (d == 2 || d == 4))};
      cur_act = (s >= DC);
      cur_d   = d;
      cur_ph  = ph;
    end
    @(posedge clock);
    #1;
    obs_v = {an, seg, dp};
    if (!reset) begin
      t = 0;
      snap = '{0, 0, 0};
    end else if (enabled) begin
      if (t % FR == FR - 1) snap = '{int'(l0), int'(l1), int'(l2)};
      t++;
    end
  endtask

  task automatic align_frame();
    while (t % FR != 0) begin
      step();
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL align: got %h want %h", obs_v, exp_v);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    enabled = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (obs_v !== 14'h3fff) begin
        bad++;
        $display("FAIL reset_hold: got %h want 3fff", obs_v);
      end
    end
    reset = 1'b1;
    step();
    total++;
    if (an !== 6'h3f) begin
      bad++;
      $display("FAIL release_e1_an: got %b want 111111", an);
    end
    step();
    total++;
    if (an !== 6'b111110 || seg !== 7'b1000000) begin
      bad++;
      $display("FAIL release_e2: got an=%b seg=%b want 111110/1000000",
               an, seg);
    end
  endtask

  task automatic test_frame();
    int cnt [6];
    int want [6] = '{7, 3, 5, 0, 9, 5};
    l0 = 6'd37; l1 = 6'd5; l2 = 6'd59;
    align_frame();
    for (int i = 0; i < 2 * FR; i++) begin
      step();
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL frame_model: got %h want %h", obs_v, exp_v);
      end
      if (i >= FR) begin
        for (int k = 0; k < 6; k++) if (an[k] === 1'b0) cnt[k]++;
        if (cur_act) begin
          total++;
          if (seg !== segc(want[cur_d]) ||
              dp !== !(cur_d == 2 || cur_d == 4)) begin
            bad++;
            $display("FAIL frame_slot%0d: got seg=%b dp=%b", cur_d, seg, dp);
          end
        end
      end
    end
    for (int k = 0; k < 6; k++) begin
      total++;
      if (cnt[k] != SD - DC) begin
        bad++;
        $display("FAIL anode_duty%0d: got %0d want %0d", k, cnt[k], SD - DC);
      end
    end
  endtask

  task automatic test_tearing();
    l0 = 6'd12;
    align_frame();
    for (int i = 0; i < FR; i++) step();
    for (int i = 0; i < 2 * FR; i++) begin
      step();
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL tear_model: got %h want %h", obs_v, exp_v);
      end
      if (i == 2) l0 = 6'd48;
      if (cur_act && cur_d == 1 && i < FR) begin
        total++;
        if (seg !== 7'b1111001) begin
          bad++;
          $display("FAIL tear_old_tens: got %b want 1111001", seg);
        end
      end
      if (cur_act && cur_d <= 1 && i >= FR) begin
        total++;
        if (seg !== (cur_d == 0 ? 7'b0000000 : 7'b0011001)) begin
          bad++;
          $display("FAIL tear_new_slot%0d: got %b", cur_d, seg);
        end
      end
    end
  endtask

  task automatic test_range();
    l2 = 6'd63;
    align_frame();
    for (int i = 0; i < FR; i++) step();
    for (int i = 0; i < FR; i++) begin
      step();
      if (cur_act && cur_d >= 4) begin
        total++;
        if (seg !== (cur_d == 4 ? 7'b0110000 : 7'b0000010)) begin
          bad++;
          $display("FAIL range_slot%0d: got %b", cur_d, seg);
        end
      end
    end
  endtask

  task automatic test_blink();
    int blanked = 0;
    int lit = 0;
    mask = 3'b010;
    for (int i = 0; i < 4 * BD; i++) begin
      step();
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL blink_model: got %h want %h", obs_v, exp_v);
      end
      if (cur_act && (cur_d == 2 || cur_d == 3)) begin
        if (seg === 7'h7f && an !== 6'h3f) blanked++;
        if (seg !== 7'h7f) lit++;
      end
    end
    total++;
    if (blanked == 0 || lit == 0) begin
      bad++;
      $display("FAIL blink_both_phases: blanked=%0d lit=%0d", blanked, lit);
    end
    mask = 3'b000;
  endtask

  task automatic test_enable();
    align_frame();
    while (t % FR != 3 * SD + 1) step();
    enabled = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (obs_v !== 14'h3fff) begin
        bad++;
        $display("FAIL enable_dark: got %h want 3fff", obs_v);
      end
    end
    enabled = 1'b1;
    step();
    total++;
    if (an !== 6'b110111 || obs_v !== exp_v) begin
      bad++;
      $display("FAIL enable_resume: got %h want %h", obs_v, exp_v);
    end
  endtask

  task automatic test_reset_mid();
    while (t % SD != 2) step();
    reset = 1'b0;
    step();
    total++;
    if (obs_v !== 14'h3fff) begin
      bad++;
      $display("FAIL reset_mid: got %h want 3fff", obs_v);
    end
    reset = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if (i % 7 == 0) begin
        l0 = 6'($urandom_range(0, 63));
        l1 = 6'($urandom_range(0, 63));
        l2 = 6'($urandom_range(0, 63));
      end
      if (i % 19 == 0) mask = 3'($urandom);
      enabled = ($urandom_range(0, 9) != 0);
      step();
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL random_model: got %h want %h", obs_v, exp_v);
      end
    end
    enabled = 1'b1;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_tearing();
    test_range();
    test_blink();
    test_enable();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
